fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for the fifo_queue block. It pops one word at a time from the FIFO.
//  Each word goes out as an asynchronous serial frame on tx: start bit, WIDTH data bits LSB
//  first, optional even-parity bit, then stop bit(s). It connects directly to the FIFO's
//  deq/data_out/empty pins and handles the FIFO's one-cycle registered read latency.
// PARAMETERS
//  WIDTH         8   data bits per frame; must equal the FIFO WIDTH
//  CLKS_PER_BIT  16  clk cycles per serial bit, >=2
//  PARITY_EN     0   1 = append an even-parity bit after the data bits
//  STOP_BITS     1   number of stop bits, 1 or 2
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous reset, active-low
//  en          in   1      1 = allowed to start new frames
//  fifo_empty  in   1      connects to FIFO empty
//  fifo_data   in   WIDTH  connects to FIFO data_out
//  fifo_deq    out  1      connects to FIFO deq; single-cycle pop request
//  tx          out  1      serial line, registered, idles high
//  busy        out  1      1 whenever state != IDLE
//  tx_done     out  1      one-cycle pulse when a frame's last stop bit ends
// BEHAVIOUR
//  Reset: clock and reset
//   - One clock; reset is asynchronous and active-low.
//   - While rst_n=0: tx=1, fifo_deq=0, busy=0, tx_done=0, state=IDLE, all counters 0.
//   - A reset mid-frame aborts the frame at once (tx returns high asynchronously).
//   - After reset deasserts, no partial frame is resumed.
//  FSM states: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE|FETCH
//  IDLE:
//   - tx=1.
//   - Move to FETCH when en=1 and fifo_empty=0, sampled at the edge.
//  FETCH (exactly 1 cycle):
//   - fifo_deq=1, decoded from the state register.
//   - fifo_deq is 0 in every other state, so there is exactly one pop per frame.
//  LOAD (exactly 1 cycle):
//   - shift register <= fifo_data; the FIFO output is valid in this cycle.
//   - Parity <= ^fifo_data.
//   - tx <= 0 at the end of the cycle.
//  Timing:
//   - The IDLE decision is made in cycle N. fifo_deq is high in N+1, capture happens in N+2.
//   - The start bit drives tx=0 in cycles N+3 .. N+2+CLKS_PER_BIT.
//   - Every bit holds for exactly CLKS_PER_BIT cycles. The bit-timer runs 0..CLKS_PER_BIT-1
//     and wraps to 0.
//  DATA:
//   - WIDTH bits, LSB first.
//   - A bit index counter ($clog2(WIDTH)+1 bits) advances on each timer wrap.
//  PARITY:
//   - Present only if PARITY_EN=1.
//   - tx = XOR of the data bits, so the count of ones over data+parity is even.
//  STOP:
//   - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - tx_done pulses high in the final cycle of STOP.
//  Frame end:
//   - If en=1 and fifo_empty=0 in the final STOP cycle, go directly to FETCH (back-to-back).
//     tx stays high through FETCH/LOAD, so frames are separated by 2 extra idle cycles.
//   - Otherwise go to IDLE.
//  en semantics:
//   - en is sampled only in IDLE and in the final STOP cycle.
//   - Dropping en mid-frame never truncates the current frame.
//  Flow control: fifo_empty is ignored outside the IDLE/STOP decision points. The stage
//   never pops an empty FIFO.
//  Frame length: total cycles = (1 + WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT, plus 2
//   fetch cycles.
// TESTING (WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1. Basic frame:
//     - Stimulus: FIFO holds 0xA5, en=1.
//     - Response: one fifo_deq pulse. tx bits = 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
//       tx_done pulses once; busy=1 for 42 cycles.
//  2. Parity:
//     - Stimulus: PARITY_EN=1, byte 0x07.
//     - Response: parity bit = 1. Frame = 0,1,1,1,0,0,0,0,0,1,1.
//  3. Empty FIFO:
//     - Stimulus: fifo_empty=1 for 100 cycles with en=1.
//     - Response: tx=1, fifo_deq=0, busy=0 throughout.
//  4. Back-to-back:
//     - Stimulus: FIFO holds 0x01 then 0x02.
//     - Response: two frames with exactly 2 high cycles between them. tx_done pulses
//       twice; exactly two deq pulses.
//  5. Enable drop:
//     - Stimulus: en -> 0 during data bit 3 of 0x55 while the FIFO still holds 0xAA.
//     - Response: 0x55 finishes completely. No second fifo_deq until en returns to 1.
//  6. Reset mid-frame:
//     - Stimulus: rst_n=0 during data bit 5.
//     - Response: tx=1 and busy=0 immediately. After release with the FIFO non-empty,
//       the next frame begins with a fresh FETCH.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drain stage for fifo_queue: pops one word per frame and serialises it on tx
// as start bit, WIDTH data bits LSB first, optional even parity, then stop bit(s).
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_deq,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [BW-1:0]    bit_idx;
    logic             stop_cnt;
    logic [WIDTH-1:0] shreg;
    logic             par;

    logic bit_end;
    logic last_stop;
    logic go;

    assign bit_end   = (timer == TW'(CLKS_PER_BIT - 1));
    assign last_stop = (state == STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
    assign go        = en && !fifo_empty;

    // Status outputs decode directly from registered state so they clear with reset.
    assign fifo_deq = (state == FETCH);
    assign busy     = (state != IDLE);
    assign tx_done  = last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
        end else begin
            // Bit timer only runs while a bit is on the line.
            if (state == START || state == DATA || state == PARITY || state == STOP) begin
                timer <= bit_end ? '0 : timer + TW'(1);
            end else begin
                timer <= '0;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (go) state <= FETCH;
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // FIFO read data is valid one cycle after the pop.
                    shreg <= fifo_data;
                    par   <= ^fifo_data;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BW'(WIDTH - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            state <= go ? FETCH : IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / 1 stop, parity / 2 stops) fed by
// behavioural FIFOs, checked against a frame-position reference model plus directed tables.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] fe;
    logic [1:0] deq;
    logic [1:0] txo;
    logic [1:0] busy;
    logic [1:0] done;
    logic [7:0] fd0;
    logic [7:0] fd1;

    logic [7:0] mem [2][256];
    logic [7:0] wp [2] = '{8'd0, 8'd0};
    logic [7:0] rp [2] = '{8'd0, 8'd0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fe[0]), .fifo_data(fd0),
        .fifo_deq(deq[0]), .tx(txo[0]), .busy(busy[0]), .tx_done(done[0])
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fe[1]), .fifo_data(fd1),
        .fifo_deq(deq[1]), .tx(txo[1]), .busy(busy[1]), .tx_done(done[1])
    );

    // Behavioural FIFOs with one-cycle registered read data.
    assign fe[0] = (wp[0] == rp[0]);
    assign fe[1] = (wp[1] == rp[1]);

    always @(posedge clk) begin
        if (deq[0]) begin
            fd0   <= mem[0][rp[0]];
            rp[0] <= rp[0] + 8'd1;
        end
        if (deq[1]) begin
            fd1   <= mem[1][rp[1]];
            rp[1] <= rp[1] + 8'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wp[k]] = d;
        wp[k] = wp[k] + 8'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each frame is a list of line bits; outputs follow from the
    // position inside the frame, counted from the cycle the pop is requested.
    int cyc = 0;
    bit act_m [2];
    int f_m [2];
    int len_m [2];
    int bits_m [2][12];

    always @(negedge clk) begin
        logic [7:0] w;
        int p;
        int n;
        logic etx, edeq, ebusy, edone;
        for (int k = 0; k < 2; k++) begin
            etx = 1'b1; edeq = 1'b0; ebusy = 1'b0; edone = 1'b0;
            if (!rst_n) act_m[k] = 1'b0;
            if (act_m[k]) begin
                p = cyc - f_m[k];
                ebusy = 1'b1;
                edeq  = (p == 0);
                if (p >= 2 && (p - 2) / C < len_m[k]) etx = (bits_m[k][(p - 2) / C] != 0);
                edone = (p == 1 + len_m[k] * C);
            end
            check($sformatf("m_tx%0d", k), int'(txo[k]), int'(etx));
            check($sformatf("m_deq%0d", k), int'(deq[k]), int'(edeq));
            check($sformatf("m_busy%0d", k), int'(busy[k]), int'(ebusy));
            check($sformatf("m_done%0d", k), int'(done[k]), int'(edone));
            if (rst_n) begin
                if ((!act_m[k] || edone) && en && !fe[k]) begin
                    w = mem[k][rp[k]];
                    bits_m[k][0] = 0;
                    for (int i = 0; i < 8; i++) bits_m[k][1 + i] = int'(w[i]);
                    n = 9;
                    if (k == 1) begin
                        bits_m[k][9] = int'(^w);
                        n = 10;
                    end
                    for (int s = 0; s <= k; s++) begin
                        bits_m[k][n] = 1;
                        n++;
                    end
                    len_m[k] = n;
                    act_m[k] = 1'b1;
                    f_m[k]   = cyc + 1;
                end else if (edone) begin
                    act_m[k] = 1'b0;
                end
            end
        end
        cyc++;
    end

    typedef struct {
        int          cfg;
        logic [7:0]  data;
        logic [11:0] bits;
        int          nbits;
        int          busy_cyc;
    } vec_t;

    initial begin
        vec_t vt [6];
        logic [11:0] cap;
        int nd, ndone, nb, dcyc, rel, bad, gap, t0, wt;
        bit meas;
        int k;

        // Line bit i of a frame is bits[i]; start bit is bit 0.
        vt[0] = '{0, 8'hA5, 12'b001101001010, 10, 42};
        vt[1] = '{1, 8'h07, 12'b111000001110, 12, 50};
        vt[2] = '{0, 8'h00, 12'b001000000000, 10, 42};
        vt[3] = '{0, 8'hFF, 12'b001111111110, 10, 42};
        vt[4] = '{1, 8'h80, 12'b111100000000, 12, 50};
        vt[5] = '{1, 8'h03, 12'b110000000110, 12, 50};

        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) tick();
        check("rst_tx", int'(txo), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_deq", int'(deq), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Directed single frames.
        for (int v = 0; v < 6; v++) begin
            k = vt[v].cfg;
            push(k, vt[v].data);
            en = 1'b1;
            cap = '0; nd = 0; ndone = 0; nb = 0; dcyc = -1;
            for (int t = 0; t < 150; t++) begin
                tick();
                if (deq[k]) begin
                    nd++;
                    if (dcyc < 0) dcyc = t;
                end
                if (done[k]) ndone++;
                if (busy[k]) nb++;
                if (dcyc >= 0) begin
                    rel = t - dcyc - 2;
                    if (rel >= 0 && rel % C == C / 2 && rel / C < vt[v].nbits) cap[rel / C] = txo[k];
                end
            end
            check($sformatf("v%0d_bits", v), int'(cap), int'(vt[v].bits));
            check($sformatf("v%0d_deq", v), nd, 1);
            check($sformatf("v%0d_done", v), ndone, 1);
            check($sformatf("v%0d_busy", v), nb, vt[v].busy_cyc);
        end

        // Empty FIFO with en high: nothing may move.
        en = 1'b1;
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (txo != 2'b11 || deq != 2'b00 || busy != 2'b00) bad++;
        end
        check("empty_idle", bad, 0);

        // Back-to-back frames.
        push(0, 8'h01);
        push(0, 8'h02);
        nd = 0; ndone = 0; gap = 0; meas = 1'b0; t0 = -1;
        for (int t = 0; t < 150; t++) begin
            tick();
            if (deq[0]) nd++;
            if (meas && t > t0) begin
                if (txo[0]) gap++;
                else meas = 1'b0;
            end
            if (done[0]) begin
                ndone++;
                if (t0 < 0) begin
                    t0 = t;
                    meas = 1'b1;
                end
            end
        end
        check("b2b_deq", nd, 2);
        check("b2b_done", ndone, 2);
        check("b2b_gap", gap, 2);

        // Enable dropped during data bit 3.
        push(0, 8'h55);
        push(0, 8'hAA);
        wt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (deq[0]) begin
                wt = 1;
                break;
            end
        end
        check("endrop_start", wt, 1);
        repeat (2 + 4 * C + 1) tick();
        en = 1'b0;
        nd = 0; ndone = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (deq[0]) nd++;
            if (done[0]) ndone++;
        end
        check("endrop_deq", nd, 0);
        check("endrop_done", ndone, 1);
        en = 1'b1;
        nd = 0; ndone = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            if (deq[0]) nd++;
            if (done[0]) ndone++;
        end
        check("enret_deq", nd, 1);
        check("enret_done", ndone, 1);

        // Reset during data bit 5.
        push(0, 8'h33);
        push(0, 8'h44);
        wt = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (deq[0]) begin
                wt = 1;
                break;
            end
        end
        check("rstmid_start", wt, 1);
        repeat (2 + 6 * C + 1) tick();
        check("rstmid_pre_tx", int'(txo[0]), int'(vt[0].bits[0]) | 1'b1 & 1'b0 | int'(8'h33 >> 5) & 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx", int'(txo), 3);
        check("rstmid_busy", int'(busy), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        wt = -1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (deq[0]) begin
                wt = t;
                break;
            end
        end
        check("rstmid_fetch", wt, 0);
        repeat (60) tick();

        // Randomised traffic and enable toggling against the model.
        for (int t = 0; t < 3000; t++) begin
            tick();
            if ($urandom_range(0, 39) == 0) begin
                k = int'($urandom_range(0, 1));
                if (8'(wp[k] - rp[k]) < 8'd200) push(k, 8'($urandom));
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
        end
        en = 1'b1;
        repeat (2000) tick();
        check("drain0", int'(fe[0]), 1);
        check("drain1", int'(fe[1]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
